// File: rtl/tx_frame_scheduler.sv
// Round-robin front end for the 802.11a transmitter: grants one of two PSDU sources,
// issues Start/LENGTH, serialises bytes LSB-first in step with header/tail, then holds an idle gap.
module tx_frame_scheduler #(
    parameter int unsigned HEADER_CYCLES = 139,
    parameter int unsigned TAIL_CYCLES   = 7,
    parameter int unsigned IFS_CYCLES    = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [11:0] length0_i,
    input  logic [11:0] length1_i,
    input  logic [7:0]  data0_i,
    input  logic [7:0]  data1_i,
    output logic [1:0]  pop_o,
    output logic [1:0]  grant_o,
    output logic [1:0]  reject_o,
    output logic        busy_o,
    output logic        tx_start_o,
    output logic        tx_input_o,
    output logic [11:0] tx_length_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_HEADER = 3'd2,
        S_PSDU   = 3'd3,
        S_TAIL   = 3'd4,
        S_IFS    = 3'd5
    } state_e;

    localparam logic [14:0] HDR_LAST  = 15'(HEADER_CYCLES - 32'd1);
    localparam logic [14:0] HDR_POP   = 15'((HEADER_CYCLES >= 32'd2) ? (HEADER_CYCLES - 32'd2) : 32'd0);
    localparam logic [14:0] TAIL_LAST = 15'(TAIL_CYCLES - 32'd1);
    localparam logic [14:0] IFS_LAST  = 15'(IFS_CYCLES - 32'd1);

    state_e      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  pop_q, pop_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  reject_q, reject_d;
    logic        busy_q, busy_d;
    logic        tx_start_q, tx_start_d;
    logic        tx_input_q, tx_input_d;
    logic [11:0] tx_length_q, tx_length_d;
    logic        done_q, done_d;

    logic        win_s;
    logic [11:0] win_len_s;
    logic [7:0]  data_sel_s;
    logic [14:0] last_bit_s;

    // When both sources request, the one that did not win last time goes first.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = ~last;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        shreg_d     = shreg_q;
        pop_d       = 2'b00;
        reject_d    = 2'b00;
        grant_d     = grant_q;
        busy_d      = busy_q;
        tx_start_d  = 1'b0;
        tx_input_d  = 1'b0;
        tx_length_d = tx_length_q;
        done_d      = 1'b0;

        win_s      = pick_winner(req_i, last_q);
        win_len_s  = win_s ? length1_i : length0_i;
        data_sel_s = grant_q[1] ? data1_i : data0_i;
        last_bit_s = {tx_length_q, 3'b000} - 15'd1;

        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    last_d = win_s;
                    if (win_len_s == 12'd0) begin
                        reject_d[win_s] = 1'b1;
                    end else begin
                        grant_d     = win_s ? 2'b10 : 2'b01;
                        tx_length_d = win_len_s;
                        busy_d      = 1'b1;
                        tx_start_d  = 1'b1;
                        state_d     = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_HEADER;
                cnt_d   = 15'd0;
                if (HEADER_CYCLES == 32'd1) begin
                    pop_d = grant_q;
                end else begin
                    pop_d = 2'b00;
                end
            end
            S_HEADER: begin
                if (cnt_q == HDR_LAST) begin
                    state_d    = S_PSDU;
                    cnt_d      = 15'd0;
                    tx_input_d = data_sel_s[0];
                    shreg_d    = {1'b0, data_sel_s[7:1]};
                end else begin
                    cnt_d = cnt_q + 15'd1;
                    if ((HEADER_CYCLES >= 32'd2) && (cnt_q == HDR_POP)) begin
                        pop_d = grant_q;
                    end else begin
                        pop_d = 2'b00;
                    end
                end
            end
            S_PSDU: begin
                if (cnt_q == last_bit_s) begin
                    state_d = S_TAIL;
                    cnt_d   = 15'd0;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                    // Bit 7 of a byte is on the line: the next head byte is loaded at this edge.
                    if (cnt_q[2:0] == 3'd7) begin
                        tx_input_d = data_sel_s[0];
                        shreg_d    = {1'b0, data_sel_s[7:1]};
                    end else begin
                        tx_input_d = shreg_q[0];
                        shreg_d    = {1'b0, shreg_q[7:1]};
                    end
                    if ((cnt_q[2:0] == 3'd6) && ((cnt_q + 15'd2) <= last_bit_s)) begin
                        pop_d = grant_q;
                    end else begin
                        pop_d = 2'b00;
                    end
                end
            end
            S_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = S_IFS;
                    cnt_d   = 15'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            S_IFS: begin
                if (cnt_q == IFS_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 15'd0;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 15'd0;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 15'd0;
            last_q      <= 1'b1;
            shreg_q     <= 8'd0;
            pop_q       <= 2'b00;
            grant_q     <= 2'b00;
            reject_q    <= 2'b00;
            busy_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_input_q  <= 1'b0;
            tx_length_q <= 12'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            shreg_q     <= shreg_d;
            pop_q       <= pop_d;
            grant_q     <= grant_d;
            reject_q    <= reject_d;
            busy_q      <= busy_d;
            tx_start_q  <= tx_start_d;
            tx_input_q  <= tx_input_d;
            tx_length_q <= tx_length_d;
            done_q      <= done_d;
        end
    end

    assign pop_o       = pop_q;
    assign grant_o     = grant_q;
    assign reject_o    = reject_q;
    assign busy_o      = busy_q;
    assign tx_start_o  = tx_start_q;
    assign tx_input_o  = tx_input_q;
    assign tx_length_o = tx_length_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler; cycle offsets are counted from the TxStart cycle (t0).
module tb_tx_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [11:0] length0_i, length1_i;
    logic [7:0]  data0_i, data1_i;
    logic [1:0]  pop_o, grant_o, reject_o;
    logic        busy_o, tx_start_o, tx_input_o, done_o;
    logic [11:0] tx_length_o;

    int checks = 0;
    int passed = 0;
    int idx0, idx1, pops0, pops1, viol;
    logic [7:0] mem0 [0:7];
    logic [7:0] mem1 [0:7];

    always #5 clk = ~clk;

    tx_frame_scheduler dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i),
        .length0_i(length0_i), .length1_i(length1_i),
        .data0_i(data0_i), .data1_i(data1_i),
        .pop_o(pop_o), .grant_o(grant_o), .reject_o(reject_o),
        .busy_o(busy_o), .tx_start_o(tx_start_o), .tx_input_o(tx_input_o),
        .tx_length_o(tx_length_o), .done_o(done_o)
    );

    // One clock; the FWFT sources advance on a pop seen before the edge.
    task automatic tick();
        logic [1:0] p;
        p = pop_o;
        @(posedge clk);
        #1;
        if (p[0] === 1'b1) idx0++;
        if (p[1] === 1'b1) idx1++;
        data0_i = mem0[idx0[2:0]];
        data1_i = mem1[idx1[2:0]];
        if (pop_o[0] === 1'b1) pops0++;
        if (pop_o[1] === 1'b1) pops1++;
        if (((pop_o & ~grant_o) != 2'b00) || (grant_o == 2'b11) || (pop_o == 2'b11)) viol++;
    endtask

    task automatic do_reset(input logic [1:0] req_v);
        rst_ni = 1'b0;
        req_i  = req_v;
        idx0 = 0; idx1 = 0;
        data0_i = mem0[0];
        data1_i = mem1[0];
        tick();
        tick();
        rst_ni = 1'b1;
        pops0 = 0; pops1 = 0; viol = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
        length0_i = 12'd0; length1_i = 12'd0;
        do_reset(2'b00);
        checks++;
        if ({pop_o, grant_o, reject_o} !== 6'b0) $display("FAIL reset_vec: got %b expected 000000", {pop_o, grant_o, reject_o});
        else passed++;
        checks++;
        if ({busy_o, tx_start_o, tx_input_o, done_o} !== 4'b0) $display("FAIL reset_ctl: got %b expected 0000", {busy_o, tx_start_o, tx_input_o, done_o});
        else passed++;
        checks++;
        if (tx_length_o !== 12'd0) $display("FAIL reset_len: got %0d expected 0", tx_length_o);
        else passed++;
        tick();
        checks++;
        if (busy_o !== 1'b0) $display("FAIL idle_noreq_busy: got %b expected 0", busy_o);
        else passed++;
    endtask

    task automatic test_basic();
        logic [15:0] bits;
        int pf, ps, dc, dn, rj, nz, gd;
        mem0[0] = 8'hA5; mem0[1] = 8'h3C;
        length0_i = 12'd2;
        do_reset(2'b00);
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        checks++;
        if ({tx_start_o, grant_o, busy_o} !== 4'b1011) $display("FAIL basic_start: got %b expected 1011", {tx_start_o, grant_o, busy_o});
        else passed++;
        checks++;
        if (tx_length_o !== 12'd2) $display("FAIL basic_len: got %0d expected 2", tx_length_o);
        else passed++;
        bits = 16'h0; pf = -1; ps = -1; dc = -1; dn = 0; rj = 0; nz = 0; gd = -1;
        for (int c = 1; c <= 185; c++) begin
            tick();
            if (pop_o[0]) begin
                if (pf < 0) pf = c;
                else if (ps < 0) ps = c;
            end
            if (c >= 140 && c <= 155) bits[c-140] = tx_input_o;
            else if (tx_input_o !== 1'b0) nz++;
            if (done_o) begin dn++; dc = c; end
            if (reject_o != 2'b00) rj++;
            if (grant_o != 2'b01 && gd < 0) gd = c;
        end
        checks++;
        if (bits !== 16'h3CA5) $display("FAIL basic_bits: got %h expected 3ca5", bits);
        else passed++;
        checks++;
        if (pf != 139 || ps != 147 || pops0 != 2) $display("FAIL basic_pop: got %0d,%0d n=%0d expected 139,147 n=2", pf, ps, pops0);
        else passed++;
        checks++;
        if (dc != 163 || dn != 1) $display("FAIL basic_done: got cycle %0d n=%0d expected 163 n=1", dc, dn);
        else passed++;
        checks++;
        if (rj != 0 || nz != 0) $display("FAIL basic_quiet: got rejects %0d stray bits %0d expected 0,0", rj, nz);
        else passed++;
        checks++;
        if (gd != 179) $display("FAIL basic_grant_drop: got %0d expected 179", gd);
        else passed++;
    endtask

    task automatic test_alternate();
        logic [1:0] gs [0:2];
        int sc [0:2];
        int dc [0:2];
        int ns, nd;
        length0_i = 12'd1; length1_i = 12'd1;
        for (int i = 0; i < 3; i++) begin gs[i] = 2'b00; sc[i] = 0; dc[i] = 0; end
        ns = 0; nd = 0;
        do_reset(2'b11);
        for (int c = 1; c <= 700 && nd < 3; c++) begin
            tick();
            if (tx_start_o && ns < 3) begin gs[ns] = grant_o; sc[ns] = c; ns++; end
            if (done_o && nd < 3) begin dc[nd] = c; nd++; end
        end
        checks++;
        if (ns != 3 || nd != 3) $display("FAIL alt_frames: got starts %0d dones %0d expected 3,3", ns, nd);
        else passed++;
        checks++;
        if ({gs[0], gs[1], gs[2]} !== 6'b011001) $display("FAIL alt_grants: got %b expected 011001", {gs[0], gs[1], gs[2]});
        else passed++;
        checks++;
        if ((sc[1] - dc[0]) != 17 || (sc[2] - dc[1]) != 17) $display("FAIL alt_gap: got %0d,%0d expected 17,17", sc[1] - dc[0], sc[2] - dc[1]);
        else passed++;
        checks++;
        if (pops0 != 2 || pops1 != 1 || viol != 0) $display("FAIL alt_pops: got %0d/%0d viol %0d expected 2/1 viol 0", pops0, pops1, viol);
        else passed++;
    endtask

    task automatic test_reject();
        int rj0, gn, st;
        length0_i = 12'd0; length1_i = 12'd1;
        do_reset(2'b00);
        req_i = 2'b01;
        rj0 = 0; gn = 0; st = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (reject_o === 2'b01) rj0++;
            if (grant_o != 2'b00) gn++;
            if (tx_start_o) st++;
        end
        checks++;
        if (rj0 != 5 || gn != 0 || st != 0) $display("FAIL reject_len0: got rej %0d grant %0d start %0d expected 5,0,0", rj0, gn, st);
        else passed++;
        req_i = 2'b11;
        tick();
        checks++;
        if ({tx_start_o, grant_o, reject_o} !== 5'b11000) $display("FAIL reject_then_src1: got %b expected 11000", {tx_start_o, grant_o, reject_o});
        else passed++;
    endtask

    task automatic test_midframe_reset();
        int dn, nz;
        mem0[0] = 8'hA5; mem0[1] = 8'h3C;
        length0_i = 12'd2; length1_i = 12'd1;
        do_reset(2'b00);
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        for (int c = 1; c <= 145; c++) tick();
        checks++;
        if (tx_input_o !== 1'b1) $display("FAIL mid_bit5: got %b expected 1", tx_input_o);
        else passed++;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        checks++;
        if ({pop_o, grant_o, reject_o, busy_o, tx_start_o, tx_input_o, done_o, tx_length_o} !== 22'd0)
            $display("FAIL mid_reset_outs: got %h expected 0", {pop_o, grant_o, reject_o, busy_o, tx_start_o, tx_input_o, done_o, tx_length_o});
        else passed++;
        pops0 = 0; dn = 0; nz = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done_o) dn++;
            if (busy_o || grant_o != 2'b00) nz++;
        end
        checks++;
        if (dn != 0 || pops0 != 0 || nz != 0) $display("FAIL mid_aborted: got done %0d pops %0d active %0d expected 0,0,0", dn, pops0, nz);
        else passed++;
        length0_i = 12'd1;
        req_i = 2'b11;
        tick();
        checks++;
        if ({tx_start_o, grant_o} !== 3'b101) $display("FAIL mid_rr_restart: got %b expected 101", {tx_start_o, grant_o});
        else passed++;
    endtask

    task automatic test_req_drop();
        int dc, gd, bd;
        length0_i = 12'd3; length1_i = 12'd0;
        do_reset(2'b00);
        req_i = 2'b01;
        tick();
        dc = -1; gd = -1; bd = -1;
        for (int c = 1; c <= 190; c++) begin
            tick();
            if (c == 150) begin req_i = 2'b00; length0_i = 12'd0; end
            if (done_o) dc = c;
            if (grant_o != 2'b01 && gd < 0) gd = c;
            if (busy_o != 1'b1 && bd < 0) bd = c;
        end
        checks++;
        if (pops0 != 3 || dc != 171) $display("FAIL drop_complete: got pops %0d done %0d expected 3,171", pops0, dc);
        else passed++;
        checks++;
        if (gd != 187 || bd != 187) $display("FAIL drop_grant_hold: got grant drop %0d busy drop %0d expected 187,187", gd, bd);
        else passed++;
    endtask

    task automatic test_long();
        int lp, fp, dc, ones;
        logic b899, b900;
        for (int i = 0; i < 8; i++) mem0[i] = 8'h00;
        mem0[6] = 8'h80;
        length0_i = 12'd4095; length1_i = 12'd0;
        do_reset(2'b00);
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        checks++;
        if (tx_length_o !== 12'd4095) $display("FAIL long_len: got %0d expected 4095", tx_length_o);
        else passed++;
        lp = -1; fp = -1; dc = -1; ones = 0; b899 = 1'b0; b900 = 1'b1;
        for (int c = 1; c <= 32920; c++) begin
            tick();
            if (pop_o[0]) begin lp = c; if (fp < 0) fp = c; end
            if (done_o) dc = c;
            if (tx_input_o) ones++;
            if (c == 32899) b899 = tx_input_o;
            if (c == 32900) b900 = tx_input_o;
        end
        checks++;
        if (pops0 != 4095 || fp != 139 || lp != 32891) $display("FAIL long_pops: got n=%0d first %0d last %0d expected 4095,139,32891", pops0, fp, lp);
        else passed++;
        checks++;
        if (b899 !== 1'b1 || b900 !== 1'b0 || ones != 512) $display("FAIL long_bits: got last %b tail %b ones %0d expected 1,0,512", b899, b900, ones);
        else passed++;
        checks++;
        if (dc != 32907) $display("FAIL long_done: got %0d expected 32907", dc);
        else passed++;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 2'b00;
        length0_i = 12'd0; length1_i = 12'd0;
        data0_i = 8'h00; data1_i = 8'h00;
        idx0 = 0; idx1 = 0; pops0 = 0; pops1 = 0; viol = 0;
        test_reset();
        test_basic();
        test_alternate();
        test_reject();
        test_midframe_reset();
        test_req_drop();
        test_long();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Front-end controller for the 802.11a serial Transmitter.
- Arbitrates round-robin between two PSDU sources (MAC queues), each presenting a 12-bit octet LENGTH and a first-word-fall-through byte stream.
- For the granted source it issues the one-shot Start and the LENGTH value.
- It then serialises the PSDU bytes LSB-first onto the Transmitter Input line, timed to the Transmitter's header/PSDU/tail sequence, and enforces an inter-frame gap before the next grant.

Parameters:
- HEADER_CYCLES, 139, number of cycles after the TxStart cycle before the first PSDU bit (preamble + SIGNAL + SERVICE).
- TAIL_CYCLES, 7, cycles of zero after the last PSDU bit.
- IFS_CYCLES, 16, idle gap after the tail before re-arbitration; must be ≥1.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req  in  2  Req[i] is high while source i holds a frame; its Data/Length are valid while Req[i] is high.
- Length0  in  12  octet count of source 0's frame.
- Length1  in  12  octet count of source 1's frame.
- Data0  in  8  head byte of source 0 (FWFT).
- Data1  in  8  head byte of source 1 (FWFT).
- Pop  out  2  one-cycle strobe: the head byte of source i is consumed at this edge.
- Grant  out  2  one-hot; identifies the source that owns the current frame.
- Reject  out  2  one-cycle strobe: request from source i was refused because its Length is 0.
- Busy  out  1  high from START through the end of IFS.
- TxStart  out  1  one-cycle Start pulse to the Transmitter.
- TxInput  out  1  serial PSDU bit to the Transmitter Input.
- TxLength  out  12  latched Length of the granted frame; held for the whole frame.
- Done  out  1  one-cycle pulse in the first IFS cycle.

Behaviour:
- Reset (Reset==0 at an edge):
  - All outputs go to 0; state goes to IDLE; counters clear.
  - The round-robin pointer is set to last=1, so source 0 wins first.
  - Reset has priority over everything. Mid-frame reset aborts the frame: no Done, no further Pop. Bytes already popped are lost.
- States: IDLE, START, HEADER, PSDU, TAIL, IFS. All outputs are registered.
- IDLE:
  - If any Req is set, pick the winner. If both are set, the winner is the source that is not `last`.
  - If the winner's Length==0: pulse Reject[winner] next cycle, set last=winner, stay in IDLE. There is no grant and no TxStart.
  - Otherwise, at the edge: set Grant[winner]=1, TxLength=Length, last=winner, and go to START.
- START: lasts exactly one cycle with TxStart=1; TxStart is the cycle after Req was sampled. Then go to HEADER.
- HEADER:
  - HEADER_CYCLES cycles, TxInput=0.
  - In the final HEADER cycle, Pop[g]=1 and Data_g is captured into an 8-bit shift register.
- PSDU:
  - Lasts 8·TxLength cycles. Let t0 be the TxStart cycle. Bit k (k=0..8L-1) appears on TxInput in cycle t0+HEADER_CYCLES+1+k.
  - Bits are sent LSB-first per byte.
  - Pop[g] pulses in cycle t0+HEADER_CYCLES+8n for n=0..L-1, with each byte captured at that edge. Pop is never asserted after byte L-1.
  - The bit counter is 15 bits wide, enough for 4095×8 = 32760.
- TAIL: TAIL_CYCLES cycles, TxInput=0.
- IFS:
  - IFS_CYCLES cycles, TxInput=0. Done=1 in the first IFS cycle only.
  - Grant and Busy drop on entry to IDLE.
  - A new frame cannot start until the cycle after IFS ends.
- Req deassertion or Length change after grant is ignored; TxLength and Grant are held until IFS ends.
- Req from the non-granted source during a frame is held off with no Reject; it is arbitrated in IDLE.
- Pop and Grant are one-hot or zero; Pop[i]=1 implies Grant[i]=1.

Test Plan:
- Req=01, Length0=2, Data0 gives 0xA5 then 0x3C → TxStart 1 cycle after Req; TxLength=2; TxInput bits (from t0+140) = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; Pop[0] at t0+139 and t0+147; Done at t0+140+16+7; 0 Reject.
- Req=11 held from reset, both Length=1 → grants alternate 01,10,01; every frame separated by ≥IFS_CYCLES idle cycles; Pop only on the granted bit.
- Req=01 with Length0=0, Req[1] low → Reject[0] pulses each IDLE evaluation; no TxStart, Grant stays 0. Then add Req[1] with Length1=1 → source 1 is granted.
- Reset low for 1 cycle at bit 5 of byte 0 → next cycle all outputs 0, state IDLE, no Done. A subsequent request from both sources grants source 0 first.
- Length0=4095 → exactly 4095 Pop pulses and 32760 PSDU bit cycles; TAIL starts at t0+139+32761; no counter wrap.
- Req[0] dropped 10 cycles into PSDU with Length0=3 → the frame completes with 3 Pops and Done; Grant is held until IFS ends.
